// File: rtl/mem_arbiter4_if.sv
// Requester-side bus of mem_arbiter4: four packed request ports plus shared response.
// lock exists only when MEM_ARBITER4_LOCK_EN is defined.
`timescale 1ns/1ps
interface mem_arbiter4_if #(
   parameter int AW = 9,
   parameter int DW = 8
);
   logic [3:0]      req;
   logic [3:0]      we;
   logic [4*AW-1:0] addr;
   logic [4*DW-1:0] wdata;
   logic [3:0]      ack;
   logic [DW-1:0]   rdata;
   logic [1:0]      owner;
   logic            busy;
`ifdef MEM_ARBITER4_LOCK_EN
   logic [3:0]      lock;

   modport master (output req, we, addr, wdata, lock, input ack, rdata, owner, busy);
   modport slave  (input req, we, addr, wdata, lock, output ack, rdata, owner, busy);
`else
   modport master (output req, we, addr, wdata, input ack, rdata, owner, busy);
   modport slave  (input req, we, addr, wdata, output ack, rdata, owner, busy);
`endif
endinterface

// File: rtl/mem_arbiter4.sv
// mem_arbiter4: round-robin arbiter of four ports onto one synchronous RAM; ack 2 cycles after grant
// for writes, 3 for reads; requesters hold req stable until ack. MEM_ARBITER4_LOCK_EN adds per-port lock.
`timescale 1ns/1ps
module mem_arbiter4 #(
   parameter int AW = 9,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter4_if.slave bus,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_we,
   input  logic [DW-1:0] ram_rdata
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WRITE   = 3'd1;
   localparam logic [2:0] S_RD_ADDR = 3'd2;
   localparam logic [2:0] S_RD_DATA = 3'd3;
   localparam logic [2:0] S_RESP    = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [1:0]    last_q, last_d;
   logic [1:0]    owner_q, owner_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic [3:0]    cand;
   logic          grant_vld;
   logic [1:0]    grant_idx;
   logic [1:0]    rr_idx;

`ifdef MEM_ARBITER4_LOCK_EN
   logic lock_q, lock_d;

   // While a lock is held only the owner may be granted; everyone else waits.
   assign cand = (lock_q && bus.lock[owner_q]) ? (bus.req & (4'b0001 << owner_q)) : bus.req;
`else
   assign cand = bus.req;
`endif

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = last_q;
      rr_idx    = last_q;
      for (int i = 1; i <= 4; i++) begin
         rr_idx = last_q + 2'(i);
         if (!grant_vld && cand[rr_idx]) begin
            grant_vld = 1'b1;
            grant_idx = rr_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
`ifdef MEM_ARBITER4_LOCK_EN
      lock_d  = lock_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef MEM_ARBITER4_LOCK_EN
            if (!bus.lock[owner_q]) lock_d = 1'b0;
`endif
            if (grant_vld) begin
               last_d  = grant_idx;
               owner_d = grant_idx;
               we_d    = bus.we[grant_idx];
               addr_d  = bus.addr[grant_idx*AW +: AW];
               wdata_d = bus.wdata[grant_idx*DW +: DW];
               state_d = bus.we[grant_idx] ? S_WRITE : S_RD_ADDR;
            end
         end
         S_WRITE:   state_d = S_RESP;
         S_RD_ADDR: state_d = S_RD_DATA;
         S_RD_DATA: begin
            rdata_d = ram_rdata;
            state_d = S_RESP;
         end
         S_RESP: begin
`ifdef MEM_ARBITER4_LOCK_EN
            lock_d  = bus.lock[owner_q];
`endif
            state_d = S_IDLE;
         end
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 2'd3;
         owner_q <= 2'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

`ifdef MEM_ARBITER4_LOCK_EN
   always_ff @(posedge clk) begin
      if (reset) lock_q <= 1'b0;
      else       lock_q <= lock_d;
   end
`endif

   assign ram_we    = (state_q == S_WRITE) && we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

   assign bus.ack   = (state_q == S_RESP) ? (4'b0001 << owner_q) : 4'b0000;
   assign bus.rdata = rdata_q;
   assign bus.owner = owner_q;
   assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter4.sv
// Directed bench for mem_arbiter4: scoreboard of expected acks in grant order plus cycle-exact checks.
`timescale 1ns/1ps
module tb_mem_arbiter4;
   localparam int AW = 9;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   mem_arbiter4_if #(.AW(AW), .DW(DW)) bus();

   mem_arbiter4 #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model with a preload path.
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic          pre_vld;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_dat;

   always @(posedge clk) begin
      if (ram_we)       mem[ram_addr] <= ram_wdata;
      else if (pre_vld) mem[pre_addr] <= pre_dat;
      ram_rdata <= mem[ram_addr];
   end

   typedef struct {
      logic [1:0]    port;
      logic          we;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.port  = p[1:0];
      e.we    = w;
      e.rdata = w ? '0 : ref_mem[a];
      if (w) ref_mem[a] = d;
      sb.push_back(e);
   endtask

   task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we[p]              = w;
      bus.addr[p*AW +: AW]   = a;
      bus.wdata[p*DW +: DW]  = d;
      bus.req[p]             = 1'b1;
      push(p, w, a, d);
   endtask

   // Requesters drop req the cycle after their ack unless in keep; endclr is dropped after the n-th ack.
   task automatic run(input int n, input logic [3:0] keep, input logic [3:0] endclr);
      int       cnt  = 0;
      bit       done = 1'b0;
      logic [3:0] seen;
      for (int c = 0; c < n*10 + 10 && !done; c++) begin
         @(negedge clk);
         seen = bus.ack;
         @(posedge clk);
         #1;
         if (seen != 4'b0) begin
            cnt++;
            if (cnt >= n) begin
               bus.req = bus.req & ~endclr;
`ifdef MEM_ARBITER4_LOCK_EN
               bus.lock = 4'b0;
`endif
               done = 1'b1;
            end else begin
               bus.req = bus.req & ~(seen & ~keep);
            end
         end
      end
      chk("run_ack_count", cnt, n);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.ack !== 4'b0) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_ack", {28'd0, bus.ack}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_ack",   {28'd0, bus.ack},   32'd1 << mon_e.port);
            chk("sb_owner", {30'd0, bus.owner}, {30'd0, mon_e.port});
            if (!mon_e.we) chk("sb_rdata", {24'd0, bus.rdata}, {24'd0, mon_e.rdata});
         end
      end
   end

   initial begin
      reset     = 1'b1;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
`ifdef MEM_ARBITER4_LOCK_EN
      bus.lock  = '0;
`endif
      pre_vld   = 1'b0;
      pre_addr  = '0;
      pre_dat   = '0;

      @(posedge clk); #1;
      pre_vld = 1'b1; pre_addr = 9'h010; pre_dat = 8'h3C;
      ref_mem[9'h010] = 8'h3C;
      @(posedge clk); #1;
      pre_vld = 1'b0;

      @(negedge clk);
      chk("rst_ack",       {28'd0, bus.ack},   32'd0);
      chk("rst_rdata",     {24'd0, bus.rdata}, 32'd0);
      chk("rst_owner",     {30'd0, bus.owner}, 32'd0);
      chk("rst_busy",      {31'd0, bus.busy},  32'd0);
      chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
      chk("rst_ram_addr",  {23'd0, ram_addr},  32'd0);
      chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Port 0 write 0xA5 -> 0x1F3.
      issue(0, 1'b1, 9'h1F3, 8'hA5);
      @(negedge clk);
      chk("w_grant_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk("w_ram_we",    {31'd0, ram_we},    32'd1);
      chk("w_ram_addr",  {23'd0, ram_addr},  32'h1F3);
      chk("w_ram_wdata", {24'd0, ram_wdata}, 32'hA5);
      chk("w_busy",      {31'd0, bus.busy},  32'd1);
      chk("w_ack_early", {28'd0, bus.ack},   32'd0);
      @(negedge clk);
      chk("w_ack",       {28'd0, bus.ack},   32'b0001);
      chk("w_ram_we_off",{31'd0, ram_we},    32'd0);
      @(posedge clk); #1;
      bus.req = '0;
      chk("w_mem", {24'd0, mem[9'h1F3]}, 32'hA5);

      // Port 2 read of preloaded 0x010.
      issue(2, 1'b0, 9'h010, 8'h00);
      @(negedge clk);
      chk("r_g0_we",   {31'd0, ram_we},   32'd0);
      @(negedge clk);
      chk("r_g1_addr", {23'd0, ram_addr}, 32'h010);
      chk("r_g1_we",   {31'd0, ram_we},   32'd0);
      @(negedge clk);
      chk("r_g2_we",   {31'd0, ram_we},   32'd0);
      chk("r_g2_ack",  {28'd0, bus.ack},  32'd0);
      @(negedge clk);
      chk("r_g3_ack",  {28'd0, bus.ack},  32'b0100);
      chk("r_g3_rdata",{24'd0, bus.rdata},32'h3C);
      chk("r_g3_we",   {31'd0, ram_we},   32'd0);
      @(posedge clk); #1;
      bus.req = '0;

      // All four ports at once after reset: order 0,1,2,3.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      issue(0, 1'b1, 9'h100, 8'h11);
      issue(1, 1'b0, 9'h010, 8'h00);
      issue(2, 1'b1, 9'h1FF, 8'h22);
      issue(3, 1'b0, 9'h1F3, 8'h00);
      run(4, 4'b0000, 4'b1111);
      chk("all4_sb_empty", sb.size(), 32'd0);

      // Port 1 holds req: re-granted only after port 2 has been served, then alone.
      issue(1, 1'b0, 9'h010, 8'h00);
      issue(2, 1'b1, 9'h020, 8'h5A);
      push(1, 1'b0, 9'h010, 8'h00);
      run(3, 4'b0010, 4'b1111);
      issue(1, 1'b1, 9'h030, 8'h77);
      push(1, 1'b1, 9'h030, 8'h77);
      run(2, 4'b0010, 4'b1111);

      // Reset during RD_DATA of a port 1 read aborts it.
      bus.we[1]          = 1'b0;
      bus.addr[1*AW +: AW] = 9'h010;
      bus.req            = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      chk("abort_rd_addr", {23'd0, ram_addr}, 32'h010);
      @(posedge clk); #1;
      reset   = 1'b1;
      bus.req = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy",  {31'd0, bus.busy},  32'd0);
      chk("abort_ack",   {28'd0, bus.ack},   32'd0);
      chk("abort_rdata", {24'd0, bus.rdata}, 32'd0);
      chk("abort_we",    {31'd0, ram_we},    32'd0);
      @(posedge clk); #1;
      issue(0, 1'b0, 9'h100, 8'h00);
      issue(2, 1'b1, 9'h040, 8'h99);
      run(2, 4'b0000, 4'b1111);
      chk("rdata_hold_after_write", {24'd0, bus.rdata}, 32'h11);

`ifdef MEM_ARBITER4_LOCK_EN
      // Port 3 locks across two reads while port 0 waits.
      bus.lock = 4'b1000;
      issue(3, 1'b0, 9'h1F3, 8'h00);
      push(3, 1'b0, 9'h1F3, 8'h00);
      issue(0, 1'b1, 9'h050, 8'h66);
      run(2, 4'b1000, 4'b1000);
      run(1, 4'b0000, 4'b1111);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("final_sb_empty", sb.size(), 32'd0);
      chk("final_mem_040",  {24'd0, mem[9'h040]}, 32'h99);
      chk("final_mem_1ff",  {24'd0, mem[9'h1FF]}, 32'h22);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
